// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 4-bit-op combinational ALU: decodes one RV32I ALU-class
// instruction per handshake, drives registered ALU inputs and returns the captured result.
module alu_issue_ctrl #(
  parameter int XLEN = 32,
  parameter int OPW  = 4,
  parameter int B2B  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  output logic [OPW-1:0]  alu_op,
  output logic [XLEN-1:0] alu_op1,
  output logic [XLEN-1:0] alu_op2,
  input  logic [XLEN-1:0] alu_res,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_res,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(4'b0000);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(4'b0001);
  localparam logic [OPW-1:0] OP_AND  = OPW'(4'b0010);
  localparam logic [OPW-1:0] OP_OR   = OPW'(4'b0011);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(4'b0100);
  localparam logic [OPW-1:0] OP_SLL  = OPW'(4'b0101);
  localparam logic [OPW-1:0] OP_SLT  = OPW'(4'b0110);
  localparam logic [OPW-1:0] OP_SLTU = OPW'(4'b0111);
  localparam logic [OPW-1:0] OP_SRL  = OPW'(4'b1000);
  localparam logic [OPW-1:0] OP_PASS = OPW'(4'b1111);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t          state_q, state_d;
  logic            load, capture;
  logic [OPW-1:0]  op_p0;
  logic [XLEN-1:0] op1_p0, op2_p0;
  logic            ill_p0, shift_p0, is_r_p0;
  logic            ill_p1;

  function automatic logic [XLEN-1:0] shamt_mask(input logic [XLEN-1:0] v);
    return {{(XLEN-5){1'b0}}, v[4:0]};
  endfunction

  // Stage p0: combinational decode of the presented instruction
  always_comb begin
    op_p0    = OP_ADD;
    op1_p0   = '0;
    op2_p0   = '0;
    ill_p0   = 1'b0;
    shift_p0 = 1'b0;
    is_r_p0  = (opcode == OPC_R);
    case (opcode)
      OPC_R, OPC_I: begin
        op1_p0 = rs1_data;
        op2_p0 = is_r_p0 ? rs2_data : imm;
        case (funct3)
          3'b000: op_p0 = (is_r_p0 && funct7_5) ? OP_SUB : OP_ADD;
          3'b001: begin
            op_p0    = OP_SLL;
            shift_p0 = 1'b1;
            ill_p0   = !is_r_p0 && funct7_5;
          end
          3'b010: op_p0 = OP_SLT;
          3'b011: op_p0 = OP_SLTU;
          3'b100: op_p0 = OP_XOR;
          3'b101: begin
            // Arithmetic right shift is not provided by this ALU
            op_p0    = OP_SRL;
            shift_p0 = 1'b1;
            ill_p0   = funct7_5;
          end
          3'b110: op_p0 = OP_OR;
          default: op_p0 = OP_AND;
        endcase
      end
      OPC_LUI: begin
        op_p0  = OP_PASS;
        op2_p0 = imm;
      end
      OPC_AUIPC: begin
        op_p0  = OP_PASS;
        op1_p0 = pc;
        op2_p0 = imm;
      end
      OPC_LOAD, OPC_STORE: begin
        op1_p0 = rs1_data;
        op2_p0 = imm;
      end
      default: ill_p0 = 1'b1;
    endcase
    if (shift_p0) op2_p0 = shamt_mask(op2_p0);
    if (ill_p0) begin
      op_p0  = OP_ADD;
      op1_p0 = '0;
      op2_p0 = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        capture = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if ((B2B != 0) && in_valid) begin
            load    = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // rst_n gates ready so upstream never sees a handshake while reset is held
  assign in_ready  = rst_n && ((state_q == IDLE) ||
                               ((state_q == DONE) && out_ready && (B2B != 0)));
  assign out_valid = (state_q == DONE);

  // Stage p1: registered ALU inputs, held until the next issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op  <= '0;
      alu_op1 <= '0;
      alu_op2 <= '0;
      ill_p1  <= 1'b0;
    end else if (load) begin
      alu_op  <= op_p0;
      alu_op1 <= op1_p0;
      alu_op2 <= op2_p0;
      ill_p1  <= ill_p0;
    end
  end

  // Stage p2: captured ALU result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_res     <= '0;
      out_illegal <= 1'b0;
    end else if (capture) begin
      out_res     <= ill_p1 ? '0 : alu_res;
      out_illegal <= ill_p1;
    end
  end

endmodule
